serial_reduced_full_sub: RTL

- Digit-serial fixed-point subtractor in the FixedPointArithmetic IP. It is the inverse-direction companion of the combinational full adder.
- Computes c = a - b - bi with a borrow chain, processing D bits per clock over N/D cycles.
- Valid/ready handshakes on both sides. Used where area matters more than latency, e.g. in multi-cycle datapaths.

---
 rtl/serial_reduced_full_sub.sv | 77 +++++++
 1 files changed

// File: rtl/serial_reduced_full_sub.sv
// serial_reduced_full_sub: digit-serial c = a - b - bi, D bits per clock over N/D cycles,
// valid/ready on both sides; borrow ripples between digits through a single register.
module serial_reduced_full_sub #(
    parameter int N = 32,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         bo,
    output logic         ov
);
    localparam int ND = N / D;
    localparam int CW = ND > 1 ? $clog2(ND) : 1;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;

    generate
        if (D < 1 || D > N || N % D != 0) begin : g_bad_digit
            $error("serial_reduced_full_sub: D must satisfy 1 <= D <= N and N %% D == 0");
        end
    endgenerate

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_r, b_r;
    logic          brw;
    logic [D:0]    diff;
    logic          last;

    // Bit D of the (D+1)-bit difference is the borrow into the next digit
    assign diff      = {1'b0, a_r[int'(cnt)*D +: D]} - {1'b0, b_r[int'(cnt)*D +: D]} - {{D{1'b0}}, brw};
    assign last      = cnt == CW'(ND - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            brw   <= 1'b0;
            c     <= '0;
            bo    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    brw   <= bi;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    c[int'(cnt)*D +: D] <= diff[D-1:0];
                    brw <= diff[D];
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        bo    <= diff[D];
                        ov    <= (a_r[N-1] != b_r[N-1]) && (diff[D-1] != a_r[N-1]);
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
